// File: rtl/axi_stream_strip_header_pkg.sv
// Shared definitions for the AXI-Stream header strip/insert blocks:
// the packet FSM state enumeration and a byte-lane popcount helper.
package axi_stream_strip_header_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        BODY,
        FLUSH
    } hdr_state_e;

    // Widest keep vector the popcount helper accepts; callers zero-extend.
    localparam int unsigned MAX_KEEP_WD = 64;

    function automatic int unsigned byte_popcount(input logic [MAX_KEEP_WD-1:0] keep);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < MAX_KEEP_WD; i++) begin
            if (keep[i]) cnt++;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axi_stream_strip_header_realign.sv
// Combinational byte realigner: appends input bytes behind res_cnt_i residual
// bytes (MSB-first) and returns the bytes that spill past one beat.
module axis_byte_realign #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic [DATA_WD-1:0]     res_data_i,
    input  logic [BYTE_CNT_WD:0]   res_cnt_i,
    input  logic [DATA_WD-1:0]     in_data_i,
    output logic [DATA_WD-1:0]     beat_o,
    output logic [DATA_WD-1:0]     rem_o
);

    localparam logic [BYTE_CNT_WD:0] FULL_CNT = (BYTE_CNT_WD+1)'(DATA_BYTE_WD);

    logic [BYTE_CNT_WD:0] h_cnt;

    // The input bytes that do not fit behind the residual are the last
    // res_cnt_i bytes of the input, i.e. the input shifted up by h bytes.
    assign h_cnt  = FULL_CNT - res_cnt_i;
    assign beat_o = res_data_i | (in_data_i >> {res_cnt_i, 3'b000});
    assign rem_o  = in_data_i << {h_cnt, 3'b000};

endmodule

// File: rtl/axi_stream_strip_header.sv
// Removes a per-packet 1..DATA_BYTE_WD byte header from an AXI-Stream packet,
// emits it as a single header beat and realigns the payload to the MSB.
module axi_stream_strip_header
    import axi_stream_strip_header_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic                    ready_header,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    ready_strip,
    output logic                    short_pkt
);

    localparam logic [BYTE_CNT_WD:0]   FULL_CNT = (BYTE_CNT_WD+1)'(DATA_BYTE_WD);
    localparam logic [BYTE_CNT_WD+1:0] FULL_TOT = (BYTE_CNT_WD+2)'(DATA_BYTE_WD);

    function automatic logic [DATA_BYTE_WD-1:0] keep_mask(input logic [BYTE_CNT_WD:0] cnt);
        return ~({DATA_BYTE_WD{1'b1}} >> cnt);
    endfunction

    function automatic logic [DATA_WD-1:0] data_mask(input logic [BYTE_CNT_WD:0] cnt);
        return ~({DATA_WD{1'b1}} >> {cnt, 3'b000});
    endfunction

    hdr_state_e               state_q, state_d;
    logic [BYTE_CNT_WD:0]     h_q, h_d, res_cnt_q, res_cnt_d;
    logic [DATA_WD-1:0]       res_data_q, res_data_d;
    logic                     valid_out_q, valid_out_d, last_out_q, last_out_d;
    logic [DATA_WD-1:0]       data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0]  keep_out_q, keep_out_d;
    logic                     valid_header_q, valid_header_d;
    logic [DATA_WD-1:0]       data_header_q, data_header_d;
    logic [DATA_BYTE_WD-1:0]  keep_header_q, keep_header_d;
    logic                     short_q, short_d;

    logic [DATA_WD-1:0]       in_data_m, beat, rem;
    logic [BYTE_CNT_WD:0]     n_in, strip_h, hdr_cnt, pay_cnt, out_cnt, spill_cnt;
    logic [BYTE_CNT_WD+1:0]   total;
    logic                     out_free, over, in_fire, strip_fire;

    always_comb begin
        in_data_m = '0;
        for (int b = 0; b < DATA_BYTE_WD; b++) begin
            if (keep_in[b]) in_data_m[8*b +: 8] = data_in[8*b +: 8];
        end
    end

    assign n_in      = (BYTE_CNT_WD+1)'(byte_popcount(MAX_KEEP_WD'(keep_in)));
    assign strip_h   = {1'b0, byte_strip_cnt} + (BYTE_CNT_WD+1)'(1);
    assign hdr_cnt   = (n_in < h_q) ? n_in : h_q;
    assign pay_cnt   = n_in - h_q;
    assign total     = {1'b0, res_cnt_q} + {1'b0, n_in};
    assign over      = total > FULL_TOT;
    assign out_cnt   = over ? FULL_CNT : total[BYTE_CNT_WD:0];
    assign spill_cnt = (BYTE_CNT_WD+1)'(total - FULL_TOT);

    // The output register may be refilled in the same cycle it is drained.
    assign out_free    = !valid_out_q || ready_out;
    assign ready_strip = (state_q == IDLE) && !valid_header_q;
    assign ready_in    = (state_q == HEAD) ? (!valid_header_q && out_free) :
                         (state_q == BODY) ? out_free : 1'b0;
    assign in_fire     = valid_in && ready_in;
    assign strip_fire  = valid_strip && ready_strip;

    axis_byte_realign #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD)
    ) u_realign (
        .res_data_i (res_data_q),
        .res_cnt_i  (res_cnt_q),
        .in_data_i  (in_data_m),
        .beat_o     (beat),
        .rem_o      (rem)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        h_d            = h_q;
        res_cnt_d      = res_cnt_q;
        res_data_d     = res_data_q;
        valid_out_d    = valid_out_q && !ready_out;
        data_out_d     = data_out_q;
        keep_out_d     = keep_out_q;
        last_out_d     = last_out_q;
        valid_header_d = valid_header_q && !ready_header;
        data_header_d  = data_header_q;
        keep_header_d  = keep_header_q;
        short_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (strip_fire) begin
                    // Residual starts empty but sized W-h so the realigner
                    // already yields the post-header bytes of the first beat.
                    h_d        = strip_h;
                    res_cnt_d  = FULL_CNT - strip_h;
                    res_data_d = '0;
                    state_d    = HEAD;
                end
            end
            HEAD: begin
                if (in_fire) begin
                    valid_header_d = 1'b1;
                    data_header_d  = in_data_m & data_mask(hdr_cnt);
                    keep_header_d  = keep_mask(hdr_cnt);
                    if (last_in) begin
                        short_d    = n_in < h_q;
                        res_cnt_d  = '0;
                        res_data_d = '0;
                        state_d    = IDLE;
                        if (n_in > h_q) begin
                            valid_out_d = 1'b1;
                            data_out_d  = rem;
                            keep_out_d  = keep_mask(pay_cnt);
                            last_out_d  = 1'b1;
                        end
                    end else begin
                        res_data_d = rem;
                        state_d    = BODY;
                    end
                end
            end
            BODY: begin
                if (in_fire) begin
                    valid_out_d = total != '0;
                    data_out_d  = beat & data_mask(out_cnt);
                    keep_out_d  = keep_mask(out_cnt);
                    last_out_d  = last_in && !over;
                    res_data_d  = rem;
                    res_cnt_d   = over ? spill_cnt : '0;
                    if (last_in) state_d = over ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                if (out_free) begin
                    valid_out_d = 1'b1;
                    data_out_d  = res_data_q;
                    keep_out_d  = keep_mask(res_cnt_q);
                    last_out_d  = 1'b1;
                    res_cnt_d   = '0;
                    res_data_d  = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, and the
    // data/keep registers are reset too so a mid-packet reset leaves nothing stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            h_q            <= '0;
            res_cnt_q      <= '0;
            res_data_q     <= '0;
            valid_out_q    <= 1'b0;
            data_out_q     <= '0;
            keep_out_q     <= '0;
            last_out_q     <= 1'b0;
            valid_header_q <= 1'b0;
            data_header_q  <= '0;
            keep_header_q  <= '0;
            short_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            h_q            <= h_d;
            res_cnt_q      <= res_cnt_d;
            res_data_q     <= res_data_d;
            valid_out_q    <= valid_out_d;
            data_out_q     <= data_out_d;
            keep_out_q     <= keep_out_d;
            last_out_q     <= last_out_d;
            valid_header_q <= valid_header_d;
            data_header_q  <= data_header_d;
            keep_header_q  <= keep_header_d;
            short_q        <= short_d;
        end
    end

    assign valid_out    = valid_out_q;
    assign data_out     = data_out_q;
    assign keep_out     = keep_out_q;
    assign last_out     = last_out_q;
    assign valid_header = valid_header_q;
    assign data_header  = data_header_q;
    assign keep_header  = keep_header_q;
    assign short_pkt    = short_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Self-checking bench for axi_stream_strip_header (W=4): directed vectors,
// mid-packet reset, then randomized packets against a byte-queue model.
module tb_axi_stream_strip_header;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [BW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic          is_strip;
        logic [CW-1:0] cnt;
        beat_t         beat;
    } stim_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in, last_in, ready_in;
    logic [DW-1:0] data_in;
    logic [BW-1:0] keep_in;
    logic          valid_out, last_out, ready_out;
    logic [DW-1:0] data_out;
    logic [BW-1:0] keep_out;
    logic          valid_header, ready_header;
    logic [DW-1:0] data_header;
    logic [BW-1:0] keep_header;
    logic          valid_strip, ready_strip, short_pkt;
    logic [CW-1:0] byte_strip_cnt;

    always #5 clk = ~clk;

    axi_stream_strip_header #(.DATA_WD(DW), .DATA_BYTE_WD(BW), .BYTE_CNT_WD(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .last_in        (last_in),
        .ready_in       (ready_in),
        .valid_out      (valid_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .ready_out      (ready_out),
        .valid_header   (valid_header),
        .data_header    (data_header),
        .keep_header    (keep_header),
        .ready_header   (ready_header),
        .valid_strip    (valid_strip),
        .byte_strip_cnt (byte_strip_cnt),
        .ready_strip    (ready_strip),
        .short_pkt      (short_pkt)
    );

    stim_t       stim_q[$];
    beat_t       exp_out[$];
    beat_t       exp_hdr[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_short = 0;
    int          short_seen = 0;
    int unsigned p_rdy_out = 100;
    int unsigned p_rdy_hdr = 100;
    int unsigned p_valid = 100;
    logic        presenting = 1'b0;
    logic        stall_pending = 1'b0;
    beat_t       held;
    logic [7:0]  pkt [0:15];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        return b;
    endfunction

    // Packs pkt[start +: cnt] MSB-first into one beat; unused lanes are zero.
    function automatic beat_t pack(input int start, input int cnt, input logic l);
        beat_t b;
        b = '0;
        for (int k = 0; k < cnt; k++) begin
            b.data[DW-1-8*k -: 8] = pkt[start+k];
            b.keep[BW-1-k]        = 1'b1;
        end
        b.last = l;
        return b;
    endfunction

    task automatic push_strip(input int h);
        stim_t s;
        s          = '0;
        s.is_strip = 1'b1;
        s.cnt      = CW'(h - 1);
        stim_q.push_back(s);
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input logic [BW-1:0] k, input logic l);
        stim_t s;
        s      = '0;
        s.beat = mk(d, k, l);
        stim_q.push_back(s);
    endtask

    // Reference: header = first min(h,len) bytes, payload = remaining bytes
    // chunked into W-byte beats, last flag on the final chunk.
    task automatic gen_packet();
        int    h, len, cnt, hl;
        beat_t b;
        stim_t s;
        h   = int'($urandom_range(1, BW));
        len = int'($urandom_range(1, 14));
        for (int k = 0; k < len; k++) pkt[k] = 8'($urandom);
        push_strip(h);
        for (int st = 0; st < len; st += BW) begin
            cnt = (len - st < BW) ? len - st : BW;
            b   = pack(st, cnt, st + BW >= len);
            for (int k = cnt; k < BW; k++) b.data[DW-1-8*k -: 8] = 8'($urandom);
            s      = '0;
            s.beat = b;
            stim_q.push_back(s);
        end
        hl = (len < h) ? len : h;
        exp_hdr.push_back(pack(0, hl, 1'b0));
        if (len < h) exp_short++;
        for (int st = h; st < len; st += BW) begin
            cnt = (len - st < BW) ? len - st : BW;
            exp_out.push_back(pack(st, cnt, st + BW >= len));
        end
    endtask

    task automatic run_cycle();
        stim_t s;
        beat_t e;
        @(negedge clk);
        ready_out    = ($urandom_range(0, 99) < p_rdy_out);
        ready_header = ($urandom_range(0, 99) < p_rdy_hdr);
        if (!presenting && stim_q.size() > 0 && $urandom_range(0, 99) < p_valid) presenting = 1'b1;
        valid_strip    = 1'b0;
        byte_strip_cnt = '0;
        valid_in       = 1'b0;
        data_in        = '0;
        keep_in        = '0;
        last_in        = 1'b0;
        if (presenting) begin
            s = stim_q[0];
            if (s.is_strip) begin
                valid_strip    = 1'b1;
                byte_strip_cnt = s.cnt;
            end else begin
                valid_in = 1'b1;
                data_in  = s.beat.data;
                keep_in  = s.beat.keep;
                last_in  = s.beat.last;
            end
        end
        #1;
        if (stall_pending) begin
            check("out_hold_valid", valid_out, 1'b1);
            check("out_hold_beat", {data_out, keep_out, last_out}, held);
        end
        if (valid_out && !ready_out) check("ready_in_blocked", ready_in, 1'b0);
        if (valid_header) check("ready_strip_blocked", ready_strip, 1'b0);
        if (short_pkt) short_seen++;
        if (valid_out && ready_out) begin
            check("out_expected", exp_out.size() != 0, 1'b1);
            if (exp_out.size() != 0) begin
                e = exp_out.pop_front();
                check("out_data", data_out, e.data);
                check("out_keep", keep_out, e.keep);
                check("out_last", last_out, e.last);
            end
        end
        if (valid_header && ready_header) begin
            check("hdr_expected", exp_hdr.size() != 0, 1'b1);
            if (exp_hdr.size() != 0) begin
                e = exp_hdr.pop_front();
                check("hdr_data", data_header, e.data);
                check("hdr_keep", keep_header, e.keep);
            end
        end
        stall_pending = valid_out && !ready_out;
        held          = mk(data_out, keep_out, last_out);
        if (presenting && ((valid_strip && ready_strip) || (valid_in && ready_in))) begin
            void'(stim_q.pop_front());
            presenting = 1'b0;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int cyc;
        cyc = 0;
        while ((presenting || stim_q.size() > 0 || exp_out.size() > 0 || exp_hdr.size() > 0)
               && cyc < budget) begin
            run_cycle();
            cyc++;
        end
        check(tag, cyc < budget, 1'b1);
        repeat (2) run_cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        valid_in       = 1'b0;
        data_in        = '0;
        keep_in        = '0;
        last_in        = 1'b0;
        ready_out      = 1'b0;
        ready_header   = 1'b0;
        valid_strip    = 1'b0;
        byte_strip_cnt = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_valid_header", valid_header, 1'b0);
        check("rst_last_out", last_out, 1'b0);
        check("rst_short_pkt", short_pkt, 1'b0);
        check("rst_ready_in", ready_in, 1'b0);
        check("rst_ready_strip", ready_strip, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, h = 2, 1, 4, 3.
        push_strip(2);
        push_beat(32'hAABB0102, 4'hF, 1'b0);
        push_beat(32'h03040506, 4'hF, 1'b1);
        exp_hdr.push_back(mk(32'hAABB0000, 4'hC, 1'b0));
        exp_out.push_back(mk(32'h01020304, 4'hF, 1'b0));
        exp_out.push_back(mk(32'h05060000, 4'hC, 1'b1));
        push_strip(1);
        push_beat(32'h11A1A2A3, 4'hF, 1'b0);
        push_beat(32'hB1B2B300, 4'hE, 1'b1);
        exp_hdr.push_back(mk(32'h11000000, 4'h8, 1'b0));
        exp_out.push_back(mk(32'hA1A2A3B1, 4'hF, 1'b0));
        exp_out.push_back(mk(32'hB2B30000, 4'hC, 1'b1));
        push_strip(4);
        push_beat(32'hDEADBEEF, 4'hF, 1'b0);
        push_beat(32'h12345678, 4'hF, 1'b1);
        exp_hdr.push_back(mk(32'hDEADBEEF, 4'hF, 1'b0));
        exp_out.push_back(mk(32'h12345678, 4'hF, 1'b1));
        push_strip(3);
        push_beat(32'hC0C10000, 4'hC, 1'b1);
        exp_hdr.push_back(mk(32'hC0C10000, 4'hC, 1'b0));
        exp_short++;
        drain("directed_done", 200);
        check("directed_short_cnt", short_seen, exp_short);

        // Park a packet mid-BODY with outputs stalled, then reset.
        p_rdy_out = 0;
        p_rdy_hdr = 0;
        push_strip(2);
        push_beat(32'h01020304, 4'hF, 1'b0);
        push_beat(32'h05060708, 4'hF, 1'b0);
        push_beat(32'h090A0B0C, 4'hF, 1'b1);
        for (int i = 0; i < 50 && stim_q.size() > 1; i++) run_cycle();
        check("reset_setup_reached", stim_q.size() <= 1, 1'b1);
        @(negedge clk);
        rst_n       = 1'b0;
        valid_in    = 1'b0;
        valid_strip = 1'b0;
        #1;
        check("midrst_valid_out", valid_out, 1'b0);
        check("midrst_valid_header", valid_header, 1'b0);
        check("midrst_ready_strip", ready_strip, 1'b1);
        check("midrst_ready_in", ready_in, 1'b0);
        stim_q.delete();
        presenting    = 1'b0;
        stall_pending = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        p_rdy_out = 100;
        p_rdy_hdr = 100;
        push_strip(2);
        push_beat(32'hAABB0102, 4'hF, 1'b0);
        push_beat(32'h03040506, 4'hF, 1'b1);
        exp_hdr.push_back(mk(32'hAABB0000, 4'hC, 1'b0));
        exp_out.push_back(mk(32'h01020304, 4'hF, 1'b0));
        exp_out.push_back(mk(32'h05060000, 4'hC, 1'b1));
        drain("post_reset_done", 100);

        // Randomized packets with backpressure on both output channels.
        p_rdy_out = 60;
        p_rdy_hdr = 50;
        p_valid   = 70;
        for (int p = 0; p < 100; p++) gen_packet();
        drain("random_done", 20000);
        check("total_short_cnt", short_seen, exp_short);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
